// File: rtl/fifo_rd_ctrl.sv
// Read-domain control for an asynchronous FIFO: write-pointer synchroniser,
// binary/gray read pointer, RAM read address and empty/level/underflow flags.
module fifo_rd_ctrl #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AEMPTY_TH   = 2
) (
  input  logic                i_rd_clk,
  input  logic                i_rd_rst,
  input  logic                i_rd_en,
  input  logic [ADDRSIZE:0]   i_wr_ptr_async,
  output logic [ADDRSIZE-1:0] o_rd_addr,
  output logic [ADDRSIZE:0]   o_rd_ptr,
  output logic                o_empty,
  output logic                o_aempty,
  output logic [ADDRSIZE:0]   o_rd_level,
  output logic                o_underflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AEMPTY_LIM = PW'(AEMPTY_TH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wptr_sync;
  logic [PW-1:0] wbin_sync;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] level_next;
  logic          rd_inc;

  // Plain flop chain; the gray code guarantees at most one bit in flight.
  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_wr_ptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wptr_sync = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of the gray bits from its position up to the MSB.
  always_comb begin
    wbin_sync = '0;
    for (int i = 0; i < PW; i++) wbin_sync[i] = ^(wptr_sync >> i);
  end

  always_comb begin
    rd_inc       = i_rd_en & ~o_empty;
    rd_bin_next  = rd_bin + PW'(rd_inc);
    rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next;
    level_next   = wbin_sync - rd_bin_next;
  end

  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      rd_bin      <= '0;
      o_rd_ptr    <= '0;
      o_empty     <= 1'b1;
      o_aempty    <= 1'b1;
      o_rd_level  <= '0;
      o_underflow <= 1'b0;
    end else begin
      rd_bin      <= rd_bin_next;
      o_rd_ptr    <= rd_gray_next;
      o_empty     <= (rd_gray_next == wptr_sync);
      o_aempty    <= (level_next <= AEMPTY_LIM);
      o_rd_level  <= level_next;
      o_underflow <= i_rd_en & o_empty;
    end
  end

  assign o_rd_addr = rd_bin[ADDRSIZE-1:0];

endmodule
